shared_mem_responder: RTL and testbench

Serves the load/store requests issued by the GPU cores during their memory stage and returns completion through `val_data`. It holds the 4096 x 8 shared memory. It arbitrates all cores round-robin and completes one access at a time. It sits between the core array and the shared memory array, and the per-core request/`val_data` pairs form the core's M/M_W handshake.

---
 rtl/gpu_mem_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 34 +++
 rtl/shared_mem_responder.sv | 142 ++++++++++++++
 tb/tb_shared_mem_responder.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_mem_pkg.sv
// Shared definitions for the shared-memory responder: memory geometry,
// responder FSM states and access opcodes.
package gpu_mem_pkg;

  localparam int ADDR_W    = 12;
  localparam int DATA_W    = 8;
  localparam int MEM_DEPTH = 4096;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  typedef enum logic {
    OP_LD,
    OP_ST
  } op_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the search starts one past the last
// grant, wraps around, and picks the first unmasked requester.
module rr_arbiter #(
  parameter int NUM_CORES = 16
) (
  input  logic [NUM_CORES-1:0] req,
  input  logic [NUM_CORES-1:0] mask,
  input  logic [3:0]           last_grant,
  output logic [NUM_CORES-1:0] grant_oh,
  output logic [3:0]           grant_idx,
  output logic                 any_grant
);

  logic [NUM_CORES-1:0] elig;
  int                   cand;

  assign elig = req & ~mask;

  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    cand      = 0;
    for (int i = 1; i <= NUM_CORES; i++) begin
      cand = (int'(last_grant) + i) % NUM_CORES;
      if (!any_grant && elig[cand]) begin
        any_grant      = 1'b1;
        grant_idx      = 4'(cand);
        grant_oh[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/shared_mem_responder.sv
// Serves core load/store requests one at a time against the 4096x8 shared
// memory, arbitrating round-robin and pulsing val_data to the served core.
//
//   state  | meaning
//   IDLE   | pick a winner and latch its op, address and data
//   ACCESS | count wait cycles; on the last one write or read the RAM
//   RESP   | pulse val_data to the granted core, mem_dat valid
module shared_mem_responder
  import gpu_mem_pkg::*;
#(
  parameter int NUM_CORES   = 16,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_CORES-1:0]        mem_req_ld,
  input  logic [NUM_CORES-1:0]        mem_req_st,
  input  logic [NUM_CORES*ADDR_W-1:0] addr_shared_memory,
  input  logic [NUM_CORES*DATA_W-1:0] mem_dat_st,
  output logic [NUM_CORES-1:0]        val_data,
  output logic [DATA_W-1:0]           mem_dat,
  output logic                        busy,
  output logic [3:0]                  grant_id
);

  localparam int              WCNT_W    = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [WCNT_W-1:0] WAIT_INIT = WCNT_W'(WAIT_CYCLES);
  localparam logic [3:0]      LAST_RST  = 4'(NUM_CORES - 1);

  logic [DATA_W-1:0] mem [0:MEM_DEPTH-1];

  state_e                 state_q, state_d;
  logic [WCNT_W-1:0]      wait_q, wait_d;
  logic [3:0]             grant_q, grant_d;
  logic [NUM_CORES-1:0]   gnt_oh_q, gnt_oh_d;
  logic [3:0]             last_q, last_d;
  op_e                    op_q, op_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d;
  logic [NUM_CORES-1:0]   val_q, val_d;
  logic                   busy_q, busy_d;
  logic [DATA_W-1:0]      mem_dat_q;
  logic                   wr_en, rd_en;

  logic [NUM_CORES-1:0]   arb_oh;
  logic [3:0]             arb_idx;
  logic                   arb_any;

  rr_arbiter #(.NUM_CORES(NUM_CORES)) u_arb (
    .req        (mem_req_ld | mem_req_st),
    .mask       (val_q),
    .last_grant (last_q),
    .grant_oh   (arb_oh),
    .grant_idx  (arb_idx),
    .any_grant  (arb_any)
  );

  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    grant_d  = grant_q;
    gnt_oh_d = gnt_oh_q;
    last_d   = last_q;
    op_d     = op_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    busy_d   = busy_q;
    val_d    = '0;
    wr_en    = 1'b0;
    rd_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          state_d  = ACCESS;
          grant_d  = arb_idx;
          gnt_oh_d = arb_oh;
          last_d   = arb_idx;
          // a simultaneous load and store is served as a load only
          op_d     = mem_req_ld[arb_idx] ? OP_LD : OP_ST;
          addr_d   = addr_shared_memory[arb_idx*ADDR_W +: ADDR_W];
          wdata_d  = mem_dat_st[arb_idx*DATA_W +: DATA_W];
          wait_d   = WAIT_INIT;
          busy_d   = 1'b1;
        end
      end
      ACCESS: begin
        if (wait_q == '0) begin
          state_d = RESP;
          val_d   = gnt_oh_q;
          wr_en   = (op_q == OP_ST);
          rd_en   = (op_q == OP_LD);
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      wait_q    <= '0;
      grant_q   <= '0;
      gnt_oh_q  <= '0;
      last_q    <= LAST_RST;
      op_q      <= OP_LD;
      addr_q    <= '0;
      wdata_q   <= '0;
      val_q     <= '0;
      busy_q    <= 1'b0;
      mem_dat_q <= '0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      grant_q  <= grant_d;
      gnt_oh_q <= gnt_oh_d;
      last_q   <= last_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      val_q    <= val_d;
      busy_q   <= busy_d;
      if (rd_en) mem_dat_q <= mem[addr_q];
    end
  end

  // RAM contents survive reset; an aborted ACCESS never reaches this edge
  always_ff @(posedge clk) begin
    if (wr_en) mem[addr_q] <= wdata_q;
  end

  assign val_data = val_q;
  assign mem_dat  = mem_dat_q;
  assign busy     = busy_q;
  assign grant_id = grant_q;

endmodule

// File: tb/tb_shared_mem_responder.sv
// Transaction-level bench for shared_mem_responder: directed scenarios plus
// random multi-core traffic checked against a round-robin/memory model.
module tb_shared_mem_responder;

  localparam int N  = 16;
  localparam int W  = 0;
  localparam int W2 = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [N-1:0]    ld_v, st_v;
  logic [N*12-1:0] addr_v;
  logic [N*8-1:0]  dat_v;
  logic [N-1:0]    val_data;
  logic [7:0]      mem_dat;
  logic            busy;
  logic [3:0]      grant_id;

  logic [N-1:0]    ld2, st2;
  logic [N*12-1:0] addr2;
  logic [N*8-1:0]  dat2;
  logic [N-1:0]    val2;
  logic [7:0]      mdat2;
  logic            busy2;
  logic [3:0]      gid2;

  logic       r_ld   [N];
  logic       r_st   [N];
  logic [11:0] r_addr[N];
  logic [7:0]  r_dat [N];

  always_comb begin
    for (int k = 0; k < N; k++) begin
      ld_v[k]           = r_ld[k];
      st_v[k]           = r_st[k];
      addr_v[k*12 +: 12] = r_addr[k];
      dat_v[k*8 +: 8]   = r_dat[k];
    end
  end

  shared_mem_responder #(.NUM_CORES(N), .WAIT_CYCLES(W)) dut (
    .clk(clk), .reset(reset),
    .mem_req_ld(ld_v), .mem_req_st(st_v),
    .addr_shared_memory(addr_v), .mem_dat_st(dat_v),
    .val_data(val_data), .mem_dat(mem_dat), .busy(busy), .grant_id(grant_id)
  );

  shared_mem_responder #(.NUM_CORES(N), .WAIT_CYCLES(W2)) dut_w2 (
    .clk(clk), .reset(reset),
    .mem_req_ld(ld2), .mem_req_st(st2),
    .addr_shared_memory(addr2), .mem_dat_st(dat2),
    .val_data(val2), .mem_dat(mdat2), .busy(busy2), .grant_id(gid2)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [N-1:0] hist [16];
  logic [7:0]   model_mem [4096];
  int           model_last;
  logic [7:0]   model_mdat;
  int           next_exp;
  int           last_pulse;
  int           glog[$];
  int           served[N];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [N-1:0] req_vec();
    logic [N-1:0] v;
    for (int k = 0; k < N; k++) v[k] = r_ld[k] | r_st[k];
    return v;
  endfunction

  function automatic int pend_cnt();
    int n = 0;
    for (int k = 0; k < N; k++) if (r_ld[k] | r_st[k]) n++;
    return n;
  endfunction

  // first requester after the previous winner, wrapping around the core ring
  function automatic int rr_pick(input logic [N-1:0] p, input int last);
    for (int i = 1; i <= N; i++) begin
      if (p[(last + i) % N]) return (last + i) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    model_last = N - 1;
    model_mdat = 8'h00;
    next_exp   = -1;
    last_pulse = -100;
  endtask

  task automatic monitor();
    logic [N-1:0] pend;
    int k, exp_k;
    if (last_pulse == cyc - 2 && hist[(cyc - 1) & 15] != '0)
      next_exp = last_pulse + 3 + W;
    if (val_data != '0) begin
      chk("onehot", 32'($onehot(val_data)), 1);
      k = 0;
      for (int i = N - 1; i >= 0; i--) if (val_data[i]) k = i;
      pend  = (cyc >= 2 + W) ? hist[(cyc - 2 - W) & 15] : '0;
      exp_k = rr_pick(pend, model_last);
      chk("winner", k, exp_k);
      if (next_exp >= 0) chk("spacing", cyc, next_exp);
      chk("grant_id", grant_id, k);
      chk("busy_resp", busy, 1);
      if (r_ld[k]) begin
        model_mdat = model_mem[r_addr[k]];
        chk("ld_data", mem_dat, model_mdat);
      end else if (r_st[k]) begin
        model_mem[r_addr[k]] = r_dat[k];
        chk("st_hold", mem_dat, model_mdat);
      end
      model_last = k;
      served[k]++;
      glog.push_back(k);
      r_ld[k] = 1'b0;
      r_st[k] = 1'b0;
      last_pulse = cyc;
      next_exp   = -1;
    end else if (next_exp == cyc) begin
      chk("pulse_due", 32'(val_data != '0), 1);
      next_exp = -1;
    end
  endtask

  task automatic step();
    hist[cyc & 15] = reset ? req_vec() : '0;
    @(negedge clk);
    cyc++;
    if (reset) monitor();
  endtask

  task automatic issue(input int k, input logic l, input logic s,
                       input logic [11:0] a, input logic [7:0] d);
    r_addr[k] = a;
    r_dat[k]  = d;
    r_ld[k]   = l;
    r_st[k]   = s;
  endtask

  task automatic clear_reqs();
    for (int k = 0; k < N; k++) begin
      r_ld[k] = 1'b0; r_st[k] = 1'b0; r_addr[k] = '0; r_dat[k] = '0;
    end
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (pend_cnt() != 0 && n < budget) begin
      step();
      n++;
    end
    if (pend_cnt() != 0) begin
      chk("timeout", pend_cnt(), 0);
      clear_reqs();
    end
    step();
    chk("pulse_width", val_data, 0);
  endtask

  task automatic dut2_txn(input logic l, input logic s, input logic [11:0] a,
                          input logic [7:0] d, output int lat, output int bcnt);
    int n0, pcyc;
    pcyc = -1;
    bcnt = 0;
    ld2[4] = l; st2[4] = s; addr2[4*12 +: 12] = a; dat2[4*8 +: 8] = d;
    n0 = cyc;
    for (int i = 0; i < 8; i++) begin
      step();
      if (busy2) bcnt++;
      if (val2 != '0 && pcyc < 0) begin
        pcyc = cyc;
        chk("w2_vd", val2, 32'h0010);
        ld2 = '0; st2 = '0;
      end
    end
    lat = (pcyc < 0) ? -1 : pcyc - n0;
  endtask

  logic [11:0] pool [8];
  int c0, n0, lat, bcnt, op;

  initial begin
    reset = 1'b0;
    clear_reqs();
    ld2 = '0; st2 = '0; addr2 = '0; dat2 = '0;
    for (int k = 0; k < N; k++) served[k] = 0;
    for (int i = 0; i < 16; i++) hist[i] = '0;
    for (int i = 0; i < 4096; i++) model_mem[i] = 8'h00;
    model_reset();

    repeat (3) step();
    chk("rst_val", val_data, 0);
    chk("rst_mdat", mem_dat, 0);
    chk("rst_busy", busy, 0);
    chk("rst_gid", grant_id, 0);
    chk("rst_busy2", busy2, 0);
    reset = 1'b1;
    step();

    // store then load from core 3
    issue(3, 1'b0, 1'b1, 12'h0A5, 8'h5C);
    wait_done(20);
    c0 = cyc;
    issue(3, 1'b1, 1'b0, 12'h0A5, 8'h00);
    wait_done(20);
    chk("ld_lat", last_pulse - c0, 2);
    chk("ld_5c", mem_dat, 8'h5C);
    chk("core3_pulses", served[3], 2);

    // three-way contention
    n0 = glog.size();
    for (int k = 0; k < 3; k++) issue(k, 1'b1, 1'b0, 12'h0A5, 8'h00);
    wait_done(30);
    chk("cont_cnt", glog.size() - n0, 3);
    for (int i = 0; i < 3; i++) chk("cont_order", glog[n0 + i], i);

    // wrap fairness between cores 15 and 0
    issue(15, 1'b1, 1'b0, 12'h0A5, 8'h00);
    wait_done(20);
    n0 = glog.size();
    issue(15, 1'b1, 1'b0, 12'h0A5, 8'h00);
    issue(0, 1'b1, 1'b0, 12'h0A5, 8'h00);
    for (int i = 0; i < 40; i++) begin
      step();
      if (glog.size() - n0 >= 4) break;
      if (!r_ld[15]) issue(15, 1'b1, 1'b0, 12'h0A5, 8'h00);
      if (!r_ld[0])  issue(0, 1'b1, 1'b0, 12'h0A5, 8'h00);
    end
    wait_done(20);
    chk("wrap_cnt", 32'(glog.size() - n0 >= 4), 1);
    if (glog.size() - n0 >= 4) begin
      chk("wrap_0", glog[n0],     0);
      chk("wrap_1", glog[n0 + 1], 15);
      chk("wrap_2", glog[n0 + 2], 0);
      chk("wrap_3", glog[n0 + 3], 15);
    end

    // load+store together is a load
    issue(5, 1'b0, 1'b1, 12'h100, 8'h22);
    wait_done(20);
    issue(5, 1'b1, 1'b1, 12'h100, 8'h99);
    wait_done(20);
    chk("dual_ld", mem_dat, 8'h22);
    issue(6, 1'b1, 1'b0, 12'h100, 8'h00);
    wait_done(20);
    chk("dual_mem", mem_dat, 8'h22);

    // reset during the ACCESS cycle of a store
    issue(7, 1'b0, 1'b1, 12'h7FF, 8'h11);
    wait_done(20);
    issue(7, 1'b0, 1'b1, 12'h7FF, 8'hAB);
    step();
    chk("acc_busy", busy, 1);
    reset = 1'b0;
    clear_reqs();
    model_reset();
    step();
    chk("mid_val", val_data, 0);
    step();
    chk("mid_val2", val_data, 0);
    chk("mid_mdat", mem_dat, 0);
    chk("mid_busy", busy, 0);
    chk("mid_gid", grant_id, 0);
    reset = 1'b1;
    step();
    issue(7, 1'b1, 1'b0, 12'h7FF, 8'h00);
    wait_done(20);
    chk("rst_ld", mem_dat, 8'h11);

    // random traffic over a pool of pre-written addresses
    pool[0] = 12'h000; pool[1] = 12'hFFF; pool[2] = 12'h0A5; pool[3] = 12'h100;
    pool[4] = 12'h7FF; pool[5] = 12'h3C3; pool[6] = 12'h800; pool[7] = 12'h555;
    for (int i = 0; i < 8; i++) issue(8 + i, 1'b0, 1'b1, pool[i], 8'($urandom));
    wait_done(60);
    for (int t = 0; t < 400; t++) begin
      for (int k = 0; k < N; k++) begin
        if (!r_ld[k] && !r_st[k] && $urandom_range(0, 7) == 0) begin
          op = $urandom_range(0, 2);
          issue(k, op != 1, op != 0, pool[$urandom_range(0, 7)], 8'($urandom));
        end
      end
      step();
    end
    wait_done(200);

    // slow-memory instance
    dut2_txn(1'b0, 1'b1, 12'h123, 8'h3C, lat, bcnt);
    chk("w2_st_lat", lat, 4);
    chk("w2_st_busy", bcnt, 4);
    dut2_txn(1'b1, 1'b0, 12'h123, 8'h00, lat, bcnt);
    chk("w2_ld_lat", lat, 4);
    chk("w2_ld_busy", bcnt, 4);
    chk("w2_ld_data", mdat2, 8'h3C);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
